// File: rtl/pb_intc.sv
// Picoblaze port-bus interrupt controller: edge-detected sources latched into PENDING,
// masked by ENABLE, and delivered one at a time through an IDLE/ASSERT/SERVICE handshake.
module pb_intc #(
    parameter logic [7:0] INTC_BASE_ADDRESS = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] irq_in,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] OFS_ENABLE  = 2'd0;
    localparam logic [1:0] OFS_PENDING = 2'd1;
    localparam logic [1:0] OFS_ACTIVE  = 2'd2;
    localparam logic [1:0] OFS_EOI     = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] irq_q;
    logic [7:0] enable_q, enable_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] active_id_q, active_id_d;
    logic [7:0] data_out_q, data_out_d;
    logic       int_q, int_d;

    logic [7:0] offset;
    logic       in_win;
    logic       wr_enable, wr_pending, wr_eoi;
    logic [7:0] rise;
    logic [7:0] masked;
    logic [2:0] idx;

    // Reads are side-effect free, so the read strobe carries no information here.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    // Window is located by offset so any base, aligned or not, decodes correctly.
    assign offset = port_id - INTC_BASE_ADDRESS;
    assign in_win = (offset[7:2] == 6'd0);

    assign wr_enable  = write_strobe && in_win && (offset[1:0] == OFS_ENABLE);
    assign wr_pending = write_strobe && in_win && (offset[1:0] == OFS_PENDING);
    assign wr_eoi     = write_strobe && in_win && (offset[1:0] == OFS_EOI);

    assign rise   = irq_in & ~irq_q;
    assign masked = pending_q & enable_q;

    // Lowest set bit wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) begin
                idx = i[2:0];
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        if (wr_enable) begin
            enable_d = data_in;
        end
    end

    // A new edge overrides a coincident W1C on the same bit.
    always_comb begin
        pending_d = pending_q;
        if (wr_pending) begin
            pending_d = pending_q & ~data_in;
        end
        pending_d = pending_d | rise;
    end

    always_comb begin
        data_out_d = 8'h00;
        if (in_win) begin
            case (offset[1:0])
                OFS_ENABLE:  data_out_d = enable_q;
                OFS_PENDING: data_out_d = pending_q;
                OFS_ACTIVE:  data_out_d = active_id_q;
                default:     data_out_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                if (masked != 8'h00) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (interrupt_ack) begin
                    state_d     = ST_SERVICE;
                    active_id_d = {1'b1, 4'b0000, idx};
                end else if (masked == 8'h00) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d        = ST_IDLE;
                    active_id_d[7] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        int_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            irq_q       <= 8'h00;
            enable_q    <= 8'h00;
            pending_q   <= 8'h00;
            active_id_q <= 8'h00;
            data_out_q  <= 8'h00;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_in;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            active_id_q <= active_id_d;
            data_out_q  <= data_out_d;
            int_q       <= int_d;
        end
    end

    // interrupt comes straight off a flop that mirrors "state is ASSERT".
    assign interrupt   = int_q;
    assign data_out    = data_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pb_intc.sv
// Directed testbench for pb_intc: one task per scenario with inline checks
// against hand-computed register values, interrupt level and FSM state.
module tb_pb_intc;

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] A_EN  = BASE + 8'd0;
    localparam logic [7:0] A_PND = BASE + 8'd1;
    localparam logic [7:0] A_AID = BASE + 8'd2;
    localparam logic [7:0] A_EOI = BASE + 8'd3;
    localparam logic [1:0] S_IDLE = 2'd0, S_ASSERT = 2'd1, S_SERVICE = 2'd2;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] irq_in;
    logic       interrupt;
    logic       interrupt_ack;
    logic [1:0] dbg_state_o;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [7:0] rd;

    pb_intc #(.INTC_BASE_ADDRESS(BASE)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .data_out(data_out), .read_strobe(read_strobe), .write_strobe(write_strobe),
        .irq_in(irq_in), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] irq_during);
        reset = 1'b0;
        irq_in = irq_during;
        port_id = 8'hFF; data_in = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
        tick(); tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // driver tasks
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        port_id = addr; data_in = data; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; port_id = 8'hFF; data_in = 8'h00;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] d);
        port_id = addr; read_strobe = 1'b1;
        tick();
        d = data_out;
        read_strobe = 1'b0; port_id = 8'hFF;
    endtask

    task automatic do_ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'h00);
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", interrupt); end
        n_asserts++;
        if (dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, S_IDLE); end
        n_asserts++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
        io_read(A_EN, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_enable: got %h expected 00", rd); end
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_active: got %h expected 00", rd); end
    endtask

    task automatic test_basic();
        do_reset(8'h00);
        io_write(A_EN, 8'h04);
        irq_in = 8'h04;
        tick();
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_int_early: got %b expected 0", interrupt); end
        tick();
        irq_in = 8'h00;
        n_asserts++;
        if (interrupt !== 1'b1) begin n_fail++; $display("FAIL basic_int_2cyc: got %b expected 1", interrupt); end
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h04) begin n_fail++; $display("FAIL basic_pending: got %h expected 04", rd); end
        do_ack();
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_int_after_ack: got %b expected 0", interrupt); end
        n_asserts++;
        if (dbg_state_o !== S_SERVICE) begin n_fail++; $display("FAIL basic_state_service: got %0d expected %0d", dbg_state_o, S_SERVICE); end
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h82) begin n_fail++; $display("FAIL basic_active: got %h expected 82", rd); end
        io_write(A_PND, 8'h04);
        io_write(A_EOI, 8'h5A);
        n_asserts++;
        if (dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL basic_state_idle: got %0d expected %0d", dbg_state_o, S_IDLE); end
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h02) begin n_fail++; $display("FAIL basic_active_eoi: got %h expected 02", rd); end
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL basic_pending_clr: got %h expected 00", rd); end
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_int_final: got %b expected 0", interrupt); end
    endtask

    task automatic test_priority();
        do_reset(8'h00);
        io_write(A_EN, 8'hFF);
        irq_in = 8'h22;
        tick();
        irq_in = 8'h00;
        tick();
        n_asserts++;
        if (interrupt !== 1'b1) begin n_fail++; $display("FAIL prio_int: got %b expected 1", interrupt); end
        do_ack();
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h81) begin n_fail++; $display("FAIL prio_active_first: got %h expected 81", rd); end
        io_write(A_PND, 8'h02);
        io_write(A_EOI, 8'h00);
        n_asserts++;
        if (interrupt !== 1'b0 || dbg_state_o !== S_IDLE) begin
            n_fail++; $display("FAIL prio_eoi_idle: got int=%b state=%0d expected int=0 state=0", interrupt, dbg_state_o);
        end
        tick();
        n_asserts++;
        if (interrupt !== 1'b1) begin n_fail++; $display("FAIL prio_reassert: got %b expected 1", interrupt); end
        do_ack();
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h85) begin n_fail++; $display("FAIL prio_active_second: got %h expected 85", rd); end
        io_write(A_PND, 8'h20);
        io_write(A_EOI, 8'h00);
        tick();
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL prio_quiet: got %b expected 0", interrupt); end
    endtask

    task automatic test_masking();
        do_reset(8'h00);
        irq_in = 8'h80;
        tick();
        irq_in = 8'h00;
        tick(); tick();
        n_asserts++;
        if (interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_int_off: got %b expected 0", interrupt); end
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h80) begin n_fail++; $display("FAIL mask_pending: got %h expected 80", rd); end
        io_write(A_EN, 8'h80);
        tick();
        n_asserts++;
        if (interrupt !== 1'b1) begin n_fail++; $display("FAIL mask_int_on: got %b expected 1", interrupt); end
    endtask

    task automatic test_drop_in_assert();
        do_reset(8'h00);
        io_write(A_EN, 8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        n_asserts++;
        if (interrupt !== 1'b1) begin n_fail++; $display("FAIL drop_int_up: got %b expected 1", interrupt); end
        io_write(A_EN, 8'h00);
        tick();
        n_asserts++;
        if (interrupt !== 1'b0 || dbg_state_o !== S_IDLE) begin
            n_fail++; $display("FAIL drop_idle: got int=%b state=%0d expected int=0 state=0", interrupt, dbg_state_o);
        end
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL drop_active: got %h expected 00", rd); end
        do_ack();
        n_asserts++;
        if (dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL ack_ignored: got %0d expected 0", dbg_state_o); end
    endtask

    task automatic test_collision();
        do_reset(8'h00);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        port_id = A_PND; data_in = 8'h01; write_strobe = 1'b1; irq_in = 8'h01;
        tick();
        write_strobe = 1'b0; port_id = 8'hFF; irq_in = 8'h00;
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h01) begin n_fail++; $display("FAIL collision_set_wins: got %h expected 01", rd); end
        io_write(A_PND, 8'h01);
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL collision_w1c: got %h expected 00", rd); end
    endtask

    task automatic test_edge_vs_level();
        do_reset(8'h00);
        irq_in = 8'h08;
        repeat (10) tick();
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h08) begin n_fail++; $display("FAIL level_pending: got %h expected 08", rd); end
        io_write(A_PND, 8'h08);
        repeat (3) tick();
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL level_no_reset: got %h expected 00", rd); end
        irq_in = 8'h00;
    endtask

    task automatic test_reset_mid_assert();
        do_reset(8'h00);
        io_write(A_EN, 8'h01);
        io_write(A_AID, 8'h00);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        io_read(A_EN, rd);
        n_asserts++;
        if (interrupt !== 1'b1 || data_out !== 8'h01) begin
            n_fail++; $display("FAIL midrst_pre: got int=%b dout=%h expected int=1 dout=01", interrupt, data_out);
        end
        #2;
        reset = 1'b0;
        #1;
        n_asserts++;
        if (interrupt !== 1'b0 || data_out !== 8'h00 || dbg_state_o !== S_IDLE) begin
            n_fail++; $display("FAIL midrst_async: got int=%b dout=%h state=%0d expected 0/00/0", interrupt, data_out, dbg_state_o);
        end
        irq_in = 8'h10;
        @(negedge clk);
        reset = 1'b1;
        tick();
        io_read(A_PND, rd);
        n_asserts++;
        if (rd !== 8'h10) begin n_fail++; $display("FAIL midrst_high_src: got %h expected 10", rd); end
        io_read(A_EN, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL midrst_enable: got %h expected 00", rd); end
        irq_in = 8'h00;
    endtask

    task automatic test_decode();
        do_reset(8'h00);
        io_write(A_EN, 8'h5A);
        io_read(A_EOI, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL decode_eoi_read: got %h expected 00", rd); end
        io_read(8'h00, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL decode_port00: got %h expected 00", rd); end
        io_write(8'h14, 8'hFF);
        io_write(8'h0F, 8'hFF);
        io_write(8'h00, 8'hFF);
        io_read(A_EN, rd);
        n_asserts++;
        if (rd !== 8'h5A) begin n_fail++; $display("FAIL decode_enable_kept: got %h expected 5A", rd); end
        io_write(A_EOI, 8'h00);
        n_asserts++;
        if (dbg_state_o !== S_IDLE) begin n_fail++; $display("FAIL eoi_idle_ignored: got %0d expected 0", dbg_state_o); end
        io_read(A_AID, rd);
        n_asserts++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL decode_active_kept: got %h expected 00", rd); end
    endtask

    initial begin
        reset = 1'b0; irq_in = 8'h00; port_id = 8'hFF; data_in = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_drop_in_assert();
        test_collision();
        test_edge_vs_level();
        test_reset_mid_assert();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
